// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, error causes, funct3
// encodings and the access legality check used at capture time.
package lsu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

  typedef enum logic [1:0] {
    EC_NONE     = 2'd0,
    EC_MISALIGN = 2'd1,
    EC_ILLEGAL  = 2'd2,
    EC_TIMEOUT  = 2'd3
  } err_cause_e;

  localparam int unsigned NUM_LANES = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Illegal encodings take priority over misalignment.
  function automatic err_cause_e check_access(logic rd, logic wr, logic [2:0] f3, logic [1:0] a);
    logic legal, misal;
    if (wr) legal = f3 inside {F3_SB, F3_SH, F3_SW};
    else    legal = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    case (f3[1:0])
      2'b01:   misal = a[0];
      2'b10:   misal = |a;
      default: misal = 1'b0;
    endcase
    if ((rd && wr) || !legal) return EC_ILLEGAL;
    if (misal)                return EC_MISALIGN;
    return EC_NONE;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension.
//   rdata_i  : raw bus word
//   addr_i   : byte offset within the word
//   funct3_i : load type (LB/LH/LW/LBU/LHU)
//   data_o   : extended 32-bit load result
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata_i >> {addr_i, 3'b000};
    case (funct3_i)
      F3_LB:   data_o = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data_o = {{16{lane[15]}}, lane[15:0]};
      F3_LW:   data_o = lane;
      F3_LBU:  data_o = {24'b0, lane[7:0]};
      F3_LHU:  data_o = {16'b0, lane[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage for a single-cycle RV32I core. Captures a load/store
// from execute, runs it on a req/gnt/rvalid bus and stalls the core until
// the access retires in DONE, where Err/ErrCause report faults.
// Optional feature macro: LSU_BUS_TIMEOUT_EN (bus timeout after
// TIMEOUT_CYCLES cycles in REQ+WAIT, ErrCause=3).
// Ports:
//   clk, reset                     : clock, sync active-high reset
//   MemRead, MemWrite, Funct3      : access request from execute
//   ALUResult, WriteData           : byte address, store data
//   ReadData, Stall, Err, ErrCause : results to core
//   bus_req/we/addr/be/wdata       : bus request channel
//   bus_gnt, bus_rvalid, bus_rdata : bus grant and load response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Err,
  output logic [1:0]  ErrCause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [NUM_LANES-1:0] bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  state_q, state_d;
  err_cause_e  cause_q, cause_d, chk;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, ext;
  logic [2:0]  f3_q;
  logic        we_q, cap, tmo;

  assign cap = (state_q == S_IDLE) && (MemRead || MemWrite);
  assign chk = check_access(MemRead, MemWrite, Funct3, ALUResult[1:0]);

  load_extend u_ext (
    .rdata_i  (bus_rdata),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ext)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || state_q == S_IDLE)              cnt_q <= '0;
    else if (state_q inside {S_REQ, S_WAIT})     cnt_q <= cnt_q + 1'b1;
  end

  // Fires on the last allowed REQ/WAIT cycle so exactly TIMEOUT_CYCLES are spent.
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    Stall   = 1'b0;
    case (state_q)
      S_IDLE: if (MemRead || MemWrite) begin
        Stall   = 1'b1;
        cause_d = chk;
        if (chk != EC_NONE) begin
          state_d = S_DONE;
          if (MemRead) rdata_d = '0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (bus_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (tmo) begin
          state_d = S_DONE;
          cause_d = EC_TIMEOUT;
          if (!we_q) rdata_d = '0;
        end
      end
      S_WAIT: begin
        Stall = 1'b1;
        if (bus_rvalid) begin
          state_d = S_DONE;
          rdata_d = ext;
        end else if (tmo) begin
          state_d = S_DONE;
          cause_d = EC_TIMEOUT;
          rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;  // DONE: core commits, never re-triggers
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= EC_NONE;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      if (cap) begin
        addr_q  <= ALUResult;
        wdata_q <= WriteData;
        f3_q    <= Funct3;
        we_q    <= MemWrite;
      end
    end
  end

  // Store lanes: byte/half replicated so the enabled lanes carry the data.
  always_comb begin
    case (f3_q)
      F3_SB, F3_LBU: begin bus_be = 4'b0001 << addr_q[1:0]; bus_wdata = {4{wdata_q[7:0]}};  end
      F3_SH, F3_LHU: begin bus_be = 4'b0011 << addr_q[1:0]; bus_wdata = {2{wdata_q[15:0]}}; end
      F3_SW:         begin bus_be = 4'b1111;                bus_wdata = wdata_q;            end
      default:       begin bus_be = 4'b0000;                bus_wdata = wdata_q;            end
    endcase
  end

  assign bus_req  = (state_q == S_REQ);
  assign bus_we   = we_q;
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign ReadData = rdata_q;
  assign Err      = (state_q == S_DONE) && (cause_q != EC_NONE);
  assign ErrCause = (state_q == S_DONE) ? cause_q : EC_NONE;

endmodule
